// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter that shares one 32-bit serial transmitter between NUM_REQ sources.
// Handshake: a requester holds req_valid/word until it sees its one-cycle req_ready pulse.
module link_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_word,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [31:0]            tx_word,
  input  logic                   tx_busy,
  output logic [2:0]             grant_id,
  output logic                   active,
  output logic                   timeout_err,
  output logic [15:0]            frames_sent,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic [2:0]           last_grant_q;
  logic [2:0]           grant_id_q;
  logic [31:0]          tx_word_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 tx_start_q;
  logic                 active_q;
  logic                 timeout_err_q;
  logic [15:0]          frames_q;

  logic                 win_found;
  logic [2:0]           win_idx;
  logic [31:0]          win_word;

  // Rotating priority: indices above last_grant first, then wrap to the low ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_word  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (3'(i) > last_grant_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_word  = req_word[32*i +: 32];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (3'(i) <= last_grant_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_word  = req_word[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 3'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_word_q     <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      frames_q      <= '0;
    end else begin
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && !tx_busy && win_found) begin
            tx_word_q    <= win_word;
            grant_id_q   <= win_idx;
            last_grant_q <= win_idx;
            tx_start_q   <= 1'b1;
            req_ready_q  <= NUM_REQ'(1) << win_idx;
            active_q     <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Busy seen on the expiry cycle still counts as a successful start.
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            frames_q <= frames_q + 16'd1;
            cnt_q    <= '0;
            state_q  <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_word     = tx_word_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_err_q;
  assign frames_sent = frames_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a rotating-priority reference model.
module tb_link_tx_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [32*NR-1:0] req_word = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [31:0]     tx_word;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            active;
  logic            timeout_err;
  logic [15:0]     frames_sent;
  logic [2:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Serializer model: busy rises the cycle after a start and stays high busy_len cycles.
  logic [7:0] busy_left;
  logic       ser_en = 1'b1;
  logic [7:0] busy_len = 8'd33;

  link_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_word(req_word), .req_ready(req_ready),
    .tx_start(tx_start), .tx_word(tx_word), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err),
    .frames_sent(frames_sent), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset)                  busy_left <= '0;
    else if (tx_start && ser_en) busy_left <= busy_len;
    else if (busy_left != 0)    busy_left <= busy_left - 8'd1;
  end
  assign tx_busy = (busy_left != 0);

  typedef struct {
    logic [NR-1:0] valid;
    logic [2:0]    exp_grant;
  } vec_t;

  vec_t vecs[16];

  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    req_word[32*idx +: 32] = w;
  endtask

  // Reference: first valid index scanning last+1, last+2, ... modulo NR.
  function automatic int ref_winner(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  initial begin
    bit ok;
    int n;
    int t0;
    logic [31:0] w;

    // Reset state.
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_tx_word", tx_word, 0);

    // Single word.
    do_reset();
    ser_en = 1'b1; busy_len = 8'd33;
    set_word(0, 32'hDEADBEEF);
    req_valid = 4'b0001; enable = 1'b1;
    wait_start(10, ok);
    chk("single_start_seen", 32'(ok), 1);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_word", tx_word, 32'hDEADBEEF);
    chk("single_grant", 32'(grant_id), 0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("single_start_width", 32'(tx_start), 0);
    chk("single_ready_width", 32'(req_ready), 0);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_busy) n = 1;
      else if (n == 1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("single_busy_fell", 32'(ok), 1);
    @(negedge clk);
    chk("single_frames", 32'(frames_sent), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!active) break;
      n++;
      @(negedge clk);
    end
    chk("single_gap_len", 32'(n), GAP);

    // Vector table: round-robin then priority rotation.
    for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 3'(i % 4)};
    vecs[8]  = '{4'b0100, 3'd2};
    vecs[9]  = '{4'b1001, 3'd3};
    vecs[10] = '{4'b1001, 3'd0};
    vecs[11] = '{4'b0110, 3'd1};
    vecs[12] = '{4'b0001, 3'd0};
    vecs[13] = '{4'b0001, 3'd0};
    vecs[14] = '{4'b1000, 3'd3};
    vecs[15] = '{4'b0011, 3'd0};
    do_reset();
    busy_len = 8'd5;
    for (int i = 0; i < NR; i++) set_word(i, 32'hA0 + 32'(i));
    enable = 1'b1;
    req_valid = vecs[0].valid;
    for (int r = 0; r < 16; r++) begin
      exp_q.push_back(32'(vecs[r].exp_grant));
      wait_start(80, ok);
      chk($sformatf("vec%0d_start_seen", r), 32'(ok), 1);
      chk($sformatf("vec%0d_grant", r), 32'(grant_id), exp_q.pop_front());
      chk($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(1) << vecs[r].exp_grant);
      chk($sformatf("vec%0d_word", r), tx_word, 32'hA0 + 32'(vecs[r].exp_grant));
      @(posedge clk); #1 req_valid = (r < 15) ? vecs[r+1].valid : '0;
      @(negedge clk);
      chk($sformatf("vec%0d_ready_width", r), 32'(req_ready), 0);
    end
    wait_idle(80, ok);
    chk("vec_idle", 32'(ok), 1);
    chk("vec_frames", 32'(frames_sent), 16);

    // Start timeout: serializer never goes busy.
    do_reset();
    ser_en = 1'b0;
    enable = 1'b1;
    req_valid = 4'b0001;
    wait_start(10, ok);
    chk("to_start_seen", 32'(ok), 1);
    t0 = cyc;
    @(posedge clk); #1 req_valid = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err) begin ok = 1'b1; break; end
    end
    chk("to_seen", 32'(ok), 1);
    chk("to_delay", 32'(cyc - t0), 17);
    @(negedge clk);
    chk("to_width", 32'(timeout_err), 0);
    chk("to_frames", 32'(frames_sent), 0);
    ser_en = 1'b1;
    wait_start(20, ok);
    chk("to_next_start", 32'(ok), 1);
    chk("to_next_delay", 32'(cyc - t0), 22);
    chk("to_next_grant", 32'(grant_id), 1);

    // Enable gating during WAIT_DONE.
    do_reset();
    busy_len = 8'd33;
    enable = 1'b1;
    req_valid = 4'b0001;
    wait_start(10, ok);
    chk("en_start_seen", 32'(ok), 1);
    @(posedge clk); #1 req_valid = 4'b0010;
    wait_busy(10, ok);
    chk("en_busy_seen", 32'(ok), 1);
    @(posedge clk); #1 enable = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_start) n++;
    end
    chk("en_no_start", 32'(n), 0);
    chk("en_frames", 32'(frames_sent), 1);
    chk("en_parked", 32'(active), 0);
    @(posedge clk); #1 enable = 1'b1;
    wait_start(2, ok);
    chk("en_resume_start", 32'(ok), 1);
    chk("en_resume_grant", 32'(grant_id), 1);

    // Reset mid-frame.
    @(posedge clk); #1 req_valid = '0;
    wait_busy(10, ok);
    chk("mid_busy_seen", 32'(ok), 1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("mid_tx_start", 32'(tx_start), 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    chk("mid_active", 32'(active), 0);
    chk("mid_frames", 32'(frames_sent), 0);
    @(posedge clk); #1 reset = 1'b0;
    req_valid = 4'b0011;
    wait_start(10, ok);
    chk("mid_tie_start", 32'(ok), 1);
    chk("mid_tie_grant", 32'(grant_id), 0);

    // Random traffic against the reference model.
    do_reset();
    busy_len = 8'($urandom_range(1, 6));
    ser_en = 1'b1;
    enable = 1'b1;
    begin
      logic [31:0]   drv_word[NR];
      logic [NR-1:0] vld;
      logic [NR-1:0] prev_vld;
      bit            accepted[NR];
      int            m_last;
      int            n_starts;
      int            last_start;
      int            win;
      bit            drained;
      vld = '0; prev_vld = '0;
      m_last = NR - 1; n_starts = 0; last_start = -1; drained = 1'b0;
      for (int i = 0; i < NR; i++) begin drv_word[i] = '0; accepted[i] = 1'b0; end
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (tx_start) begin
          win = ref_winner(prev_vld, m_last);
          chk("rand_has_winner", 32'(win >= 0), 1);
          if (win >= 0) begin
            chk("rand_grant", 32'(grant_id), 32'(win));
            chk("rand_ready", 32'(req_ready), 32'(1) << win);
            chk("rand_word", tx_word, drv_word[win]);
            accepted[win] = 1'b1;
            m_last = win;
          end
          if (last_start >= 0)
            chk("rand_spacing", 32'((cyc - last_start) >= (int'(busy_len) + 3 + GAP)), 1);
          last_start = cyc;
          n_starts++;
        end
        prev_vld = req_valid;
        if (c >= 1500 && vld == '0 && !active) begin drained = 1'b1; break; end
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
          if (accepted[i]) begin vld[i] = 1'b0; accepted[i] = 1'b0; end
          if (!vld[i] && c < 1500 && $urandom_range(0, 3) == 0) begin
            drv_word[i] = $urandom;
            vld[i] = 1'b1;
          end
          req_word[32*i +: 32] = drv_word[i];
        end
        req_valid = vld;
      end
      chk("rand_drained", 32'(drained), 1);
      chk("rand_frames", 32'(frames_sent), 32'(n_starts));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
